// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared ALU op-code constants and execute-unit FSM encodings.
//            The ALU control decoder uses the same op-code constants.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_NOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_ADDU = 4'd8;
   localparam logic [3:0] ALU_SUBU = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } alu_state_t;

   // True for the two ops that run through the serial shifter
   function automatic logic is_shift_op(input logic [3:0] op);
      return (op == ALU_SRL) || (op == ALU_SLL);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_serial_shifter.sv
`default_nettype none
// ============================================================================
// Module   : alu_serial_shifter
// Brief    : Shifts a working register one bit per cycle, zero-filling, for
//            the loaded amount. done is high during the final shift cycle and
//            dout_next carries the value that shift produces.
// Revision : 1.0 - initial release
// ============================================================================
module alu_serial_shifter #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             left,
   input  logic [WIDTH-1:0] din,
   input  logic [SHW-1:0]   amount,
   output logic [WIDTH-1:0] dout_next,
   output logic             done
);

   logic [WIDTH-1:0] r_work;
   logic [SHW-1:0]   r_cnt;
   logic             r_left;

   // One-bit zero-filled shift of the working register in the latched direction
   always_comb begin
      dout_next = r_left ? {r_work[WIDTH-2:0], 1'b0} : {1'b0, r_work[WIDTH-1:1]};
      done      = (r_cnt == SHW'(1));
   end

   // Load on start, then shift and count down until the counter empties
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_work <= '0;
         r_cnt  <= '0;
         r_left <= 1'b0;
      end else if (start) begin
         r_work <= din;
         r_cnt  <= amount;
         r_left <= left;
      end else if (r_cnt != '0) begin
         r_work <= dout_next;
         r_cnt  <= r_cnt - SHW'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Brief    : Execute unit for the 4-bit alu_op code. One op at a time over a
//            valid/ready handshake; single-cycle ops register immediately,
//            shifts run serially. Result and flags are held under backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [SHW-1:0]   shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             illegal
);

   alu_state_t       r_state;
   alu_state_t       w_state_nxt;
   logic             w_accept;
   logic             w_serial;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_calc;
   logic             w_ovf;
   logic             w_illegal;
   logic [WIDTH-1:0] w_shift_next;
   logic             w_shift_done;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_overflow;
   logic             r_illegal;

   assign w_accept = in_valid && in_ready;
   // Shift by zero completes in a single cycle like any other op
   assign w_serial = is_shift_op(alu_op) && (shamt != '0);

   alu_serial_shifter #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_shifter (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (w_accept && w_serial),
      .left      (alu_op == ALU_SLL),
      .din       (op_a),
      .amount    (shamt),
      .dout_next (w_shift_next),
      .done      (w_shift_done)
   );

   // Single-cycle datapath: result, signed overflow for add/sub, illegal decode
   always_comb begin
      w_sum     = op_a + op_b;
      w_diff    = op_a - op_b;
      w_calc    = '0;
      w_ovf     = 1'b0;
      w_illegal = 1'b0;
      case (alu_op)
         ALU_ADD: begin
            w_calc = w_sum;
            w_ovf  = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (w_sum[WIDTH-1] != op_a[WIDTH-1]);
         end
         ALU_SUB: begin
            w_calc = w_diff;
            w_ovf  = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (w_diff[WIDTH-1] != op_a[WIDTH-1]);
         end
         ALU_AND:  w_calc = op_a & op_b;
         ALU_OR:   w_calc = op_a | op_b;
         ALU_XOR:  w_calc = op_a ^ op_b;
         ALU_NOR:  w_calc = ~(op_a | op_b);
         ALU_SRL:  w_calc = op_a;
         ALU_SLL:  w_calc = op_a;
         ALU_ADDU: w_calc = w_sum;
         ALU_SUBU: w_calc = w_diff;
         default:  w_illegal = 1'b1;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state and handshake outputs; DONE with out_ready accepts like IDLE
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (w_accept) w_state_nxt = w_serial ? ST_SHIFT : ST_DONE;
         end
         ST_SHIFT: begin
            if (w_shift_done) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (w_accept)       w_state_nxt = w_serial ? ST_SHIFT : ST_DONE;
            else if (out_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Output registers: loaded at a single-cycle accept or at the last shift
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result   <= '0;
         r_zero     <= 1'b0;
         r_overflow <= 1'b0;
         r_illegal  <= 1'b0;
      end else if (w_accept && !w_serial) begin
         r_result   <= w_calc;
         r_zero     <= (w_calc == '0);
         r_overflow <= w_ovf;
         r_illegal  <= w_illegal;
      end else if (r_state == ST_SHIFT && w_shift_done) begin
         r_result   <= w_shift_next;
         r_zero     <= (w_shift_next == '0);
         r_overflow <= 1'b0;
         r_illegal  <= 1'b0;
      end
   end

   assign result   = r_result;
   assign zero     = r_zero;
   assign overflow = r_overflow;
   assign illegal  = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Brief    : Directed self-checking bench for alu_exec_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_op;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [4:0]  shamt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        overflow;
   logic        illegal;

   int checks = 0;
   int errors = 0;
   int lat;
   logic rdy_seen;

   alu_exec_unit #(.WIDTH(32), .SHW(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .op_a      (op_a),
      .op_b      (op_b),
      .shamt     (shamt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .overflow  (overflow),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh);
      alu_op   = op;
      op_a     = a;
      op_b     = b;
      shamt    = sh;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check(tag, {31'd0, out_valid}, 32'd0);
   endtask

   task automatic wait_valid(output int l, output logic rdy);
      l   = 1;
      rdy = 1'b0;
      while (out_valid !== 1'b1 && l < 100) begin
         if (in_ready) rdy = 1'b1;
         step();
         l++;
      end
   endtask

   initial begin
      in_valid  = 1'b0;
      alu_op    = '0;
      op_a      = '0;
      op_b      = '0;
      shamt     = '0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_result",    result, 32'd0);
      check("rst_zero",      {31'd0, zero}, 32'd0);
      check("rst_overflow",  {31'd0, overflow}, 32'd0);
      check("rst_illegal",   {31'd0, illegal}, 32'd0);
      check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
      rst_n = 1'b1;
      step();

      // add with signed overflow, one-cycle latency
      issue(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0);
      check("add_valid",    {31'd0, out_valid}, 32'd1);
      check("add_result",   result, 32'h8000_0000);
      check("add_overflow", {31'd0, overflow}, 32'd1);
      check("add_zero",     {31'd0, zero}, 32'd0);
      drain("add_drain");

      // addu same operands: no overflow
      issue(ALU_ADDU, 32'h7FFF_FFFF, 32'd1, 5'd0);
      check("addu_result",   result, 32'h8000_0000);
      check("addu_overflow", {31'd0, overflow}, 32'd0);
      drain("addu_drain");

      // sub to zero
      issue(ALU_SUB, 32'd5, 32'd5, 5'd0);
      check("sub_result",   result, 32'd0);
      check("sub_zero",     {31'd0, zero}, 32'd1);
      check("sub_overflow", {31'd0, overflow}, 32'd0);
      drain("sub_drain");

      // sub with signed overflow: min_int - 1
      issue(ALU_SUB, 32'h8000_0000, 32'd1, 5'd0);
      check("subovf_result",   result, 32'h7FFF_FFFF);
      check("subovf_overflow", {31'd0, overflow}, 32'd1);
      drain("subovf_drain");

      // sll by 31: 32 cycles, in_ready low throughout
      issue(ALU_SLL, 32'd1, 32'd0, 5'd31);
      wait_valid(lat, rdy_seen);
      check("sll_latency",  lat, 32'd32);
      check("sll_in_ready", {31'd0, rdy_seen}, 32'd0);
      check("sll_result",   result, 32'h8000_0000);
      drain("sll_drain");

      // srl by 4: 5 cycles
      issue(ALU_SRL, 32'h8000_0000, 32'd0, 5'd4);
      wait_valid(lat, rdy_seen);
      check("srl_latency", lat, 32'd5);
      check("srl_result",  result, 32'h0800_0000);
      drain("srl_drain");

      // shift by zero passes A through in one cycle
      issue(ALU_SLL, 32'h0000_00A5, 32'd0, 5'd0);
      check("sll0_valid",  {31'd0, out_valid}, 32'd1);
      check("sll0_result", result, 32'h0000_00A5);
      drain("sll0_drain");

      // backpressure: hold output while inputs toggle
      issue(ALU_AND, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 5'd0);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         alu_op   = ALU_XOR;
         op_a     = $urandom;
         op_b     = $urandom;
         step();
      end
      check("bp_valid",    {31'd0, out_valid}, 32'd1);
      check("bp_result",   result, 32'h3030_3030);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b0;
      drain("bp_single_transfer");

      // back-to-back or, xor, nor
      out_ready = 1'b1;
      alu_op = ALU_OR;  op_a = 32'h0000_0F00; op_b = 32'h0000_00F0; in_valid = 1'b1;
      step();
      check("b2b_or_valid", {31'd0, out_valid}, 32'd1);
      check("b2b_or",       result, 32'h0000_0FF0);
      alu_op = ALU_XOR; op_a = 32'hFF00_FF00; op_b = 32'hFFFF_0000;
      step();
      check("b2b_xor_valid", {31'd0, out_valid}, 32'd1);
      check("b2b_xor",       result, 32'h00FF_FF00);
      alu_op = ALU_NOR; op_a = 32'd0; op_b = 32'd0;
      step();
      check("b2b_nor_valid", {31'd0, out_valid}, 32'd1);
      check("b2b_nor",       result, 32'hFFFF_FFFF);
      check("b2b_nor_zero",  {31'd0, zero}, 32'd0);
      in_valid = 1'b0;
      step();
      check("b2b_idle", {31'd0, out_valid}, 32'd0);
      out_ready = 1'b0;

      // illegal op
      issue(4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0);
      check("ill_valid",   {31'd0, out_valid}, 32'd1);
      check("ill_flag",    {31'd0, illegal}, 32'd1);
      check("ill_result",  result, 32'd0);
      check("ill_zero",    {31'd0, zero}, 32'd1);
      check("ill_overflow",{31'd0, overflow}, 32'd0);
      drain("ill_drain");

      // legal op clears illegal; -1 + 1 wraps to zero without overflow
      issue(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 5'd0);
      check("wrap_result",   result, 32'd0);
      check("wrap_zero",     {31'd0, zero}, 32'd1);
      check("wrap_overflow", {31'd0, overflow}, 32'd0);
      check("wrap_illegal",  {31'd0, illegal}, 32'd0);
      drain("wrap_drain");

      // reset in the middle of a shift abandons it
      issue(ALU_SLL, 32'd1, 32'd0, 5'd10);
      step();
      step();
      check("midrst_busy", {31'd0, in_ready}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_in_ready",  {31'd0, in_ready}, 32'd1);
      step();
      rst_n = 1'b1;
      repeat (12) step();
      check("postrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("postrst_in_ready",  {31'd0, in_ready}, 32'd1);
      check("postrst_result",    result, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
